// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debouncer, edge pulses and
// hold-to-auto-repeat per channel. All channels are independent and share one clock.
module button_conditioner #(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned COUNT_MAX   = 2_000_000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_MAX    = 50_000_000,
    parameter int unsigned REPEAT_MAX  = 10_000_000,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] noisy_in,
    input  logic              repeat_en,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    localparam int unsigned DB_W      = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam int unsigned TIMER_MAX = (HOLD_MAX > REPEAT_MAX) ? HOLD_MAX : REPEAT_MAX;
    localparam int unsigned HOLD_W    = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(COUNT_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_MAX - 1);

    typedef enum logic [1:0] {StReleased, StPressed, StRepeating} hold_state_e;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        logic                   stable_q, stable_d;
        logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
        logic                   rise, fall;
        hold_state_e            state_q, state_d;
        logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
        logic                   fire;
        logic                   press_q, release_q, repeat_q;

        // Polarity is corrected before the first flop so reset holds the inactive value.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in[ch] ^ ACTIVE_LOW};
            end
        end

        assign sync = sync_q[SYNC_STAGES-1];

        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (sync != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = sync;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        assign rise = stable_d & ~stable_q;
        assign fall = ~stable_d & stable_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q  <= 1'b0;
                db_cnt_q  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                stable_q  <= stable_d;
                db_cnt_q  <= db_cnt_d;
                press_q   <= rise;
                release_q <= fall;
                repeat_q  <= fire;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q    <= StReleased;
                hold_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            if (!repeat_en) begin
                // With repeat disabled the state only mirrors the level, timer parked at 0.
                state_d    = stable_d ? StPressed : StReleased;
                hold_cnt_d = '0;
            end else if (fall) begin
                state_d    = StReleased;
                hold_cnt_d = '0;
            end else begin
                unique case (state_q)
                    StReleased: begin
                        if (rise) begin
                            state_d    = StPressed;
                            hold_cnt_d = '0;
                        end
                    end
                    StPressed: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = StRepeating;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    StRepeating: begin
                        if (hold_cnt_q == REPEAT_LAST) begin
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_d    = StReleased;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end

        always_comb begin
            fire = 1'b0;
            if (repeat_en && !fall) begin
                case (state_q)
                    StPressed:   fire = (hold_cnt_q == HOLD_LAST);
                    StRepeating: fire = (hold_cnt_q == REPEAT_LAST);
                    default:     fire = 1'b0;
                endcase
            end
        end

        assign level[ch]         = stable_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = release_q;
        assign repeat_pulse[ch]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: three instances (active-high, active-low,
// minimum-window corner) compared each cycle against a sample-history reference model.
module tb_button_conditioner;

    localparam int NI   = 3;
    localparam int MAXE = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       repeat_en = 1'b1;
    logic [1:0] in_a = 2'b00;
    logic [1:0] in_b = 2'b11;
    logic [1:0] lvl [NI];
    logic [1:0] prs [NI];
    logic [1:0] rls [NI];
    logic [1:0] rpt [NI];

    button_conditioner #(.NUM_CH(2), .COUNT_MAX(4), .SYNC_STAGES(2), .HOLD_MAX(10),
                         .REPEAT_MAX(3), .ACTIVE_LOW(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .noisy_in(in_a), .repeat_en(repeat_en),
        .level(lvl[0]), .press(prs[0]), .release_pulse(rls[0]), .repeat_pulse(rpt[0]));

    button_conditioner #(.NUM_CH(2), .COUNT_MAX(4), .SYNC_STAGES(2), .HOLD_MAX(10),
                         .REPEAT_MAX(3), .ACTIVE_LOW(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .noisy_in(in_b), .repeat_en(repeat_en),
        .level(lvl[1]), .press(prs[1]), .release_pulse(rls[1]), .repeat_pulse(rpt[1]));

    button_conditioner #(.NUM_CH(2), .COUNT_MAX(1), .SYNC_STAGES(3), .HOLD_MAX(1),
                         .REPEAT_MAX(1), .ACTIVE_LOW(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .noisy_in(in_a), .repeat_en(repeat_en),
        .level(lvl[2]), .press(prs[2]), .release_pulse(rls[2]), .repeat_pulse(rpt[2]));

    int    p_al [NI] = '{0, 1, 0};
    int    p_cm [NI] = '{4, 4, 1};
    int    p_ss [NI] = '{2, 2, 3};
    int    p_hm [NI] = '{10, 10, 1};
    int    p_rm [NI] = '{3, 3, 1};
    string nm   [NI] = '{"a", "b", "c"};

    // Model: per-edge history of corrected samples and of what the debouncer saw.
    bit samp  [NI][2][MAXE];
    bit syncv [NI][2][MAXE];
    bit m_lvl [NI][2];
    bit e_prs [NI][2];
    bit e_rls [NI][2];
    bit e_rpt [NI][2];
    int anchor [NI][2];
    int ecount = 0;
    int last_rst = 0;

    int n_checks = 0;
    int n_errors = 0;

    // Event bookkeeping for directed timing checks (instance a, channel 0 unless noted).
    int n_prs0, n_rls0, n_rpt0, n_ev1;
    int prs_edge0, rls_edge0, first_rpt0, last_rpt0, both_edge_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     tag, got, got, exp, exp, ecount);
        end
    endtask

    task automatic clear_events();
        n_prs0 = 0; n_rls0 = 0; n_rpt0 = 0; n_ev1 = 0;
        prs_edge0 = -1000; rls_edge0 = -1000; first_rpt0 = -1000; last_rpt0 = -1000;
        both_edge_b = -1000;
    endtask

    task automatic model_edge(input logic [1:0] ia, input logic [1:0] ib, input logic en,
                              input logic rst);
        bit raw, flip, rise, fall;
        int k;
        ecount++;
        if (ecount >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected below %0d", ecount, MAXE);
            $fatal(1);
        end
        if (rst) last_rst = ecount;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 2; c++) begin
                raw = (i == 1) ? ib[c] : ia[c];
                samp[i][c][ecount] = raw ^ (p_al[i] != 0);
                e_prs[i][c] = 1'b0;
                e_rls[i][c] = 1'b0;
                e_rpt[i][c] = 1'b0;
                if (rst) begin
                    m_lvl[i][c] = 1'b0;
                    anchor[i][c] = -1;
                    syncv[i][c][ecount] = 1'b0;
                end else begin
                    syncv[i][c][ecount] = (ecount - 1 - last_rst < p_ss[i]) ? 1'b0 :
                                          samp[i][c][ecount - p_ss[i]];
                    // Level flips once the last COUNT_MAX synchronised samples all disagree.
                    flip = (ecount - last_rst >= p_cm[i]);
                    for (int j = 0; j < p_cm[i]; j++) begin
                        if (flip && syncv[i][c][ecount - j] == m_lvl[i][c]) flip = 1'b0;
                    end
                    rise = flip && !m_lvl[i][c];
                    fall = flip && m_lvl[i][c];
                    if (flip) m_lvl[i][c] = ~m_lvl[i][c];
                    e_prs[i][c] = rise;
                    e_rls[i][c] = fall;
                    if (!m_lvl[i][c]) begin
                        anchor[i][c] = -1;
                    end else if (rise || !en) begin
                        anchor[i][c] = ecount;
                    end else begin
                        k = ecount - anchor[i][c];
                        e_rpt[i][c] = (k >= p_hm[i]) && ((k - p_hm[i]) % p_rm[i] == 0);
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic [1:0] ia, input logic [1:0] ib, input logic en,
                         input logic rst);
        in_a = ia;
        in_b = ib;
        repeat_en = en;
        reset = rst;
        @(posedge clk);
        model_edge(ia, ib, en, rst);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_eq({nm[i], ".level"},  32'(lvl[i]), {30'b0, m_lvl[i][1], m_lvl[i][0]});
            check_eq({nm[i], ".press"},  32'(prs[i]), {30'b0, e_prs[i][1], e_prs[i][0]});
            check_eq({nm[i], ".release"}, 32'(rls[i]), {30'b0, e_rls[i][1], e_rls[i][0]});
            check_eq({nm[i], ".repeat"}, 32'(rpt[i]), {30'b0, e_rpt[i][1], e_rpt[i][0]});
        end
        if (prs[0][0]) begin n_prs0++; prs_edge0 = ecount; end
        if (rls[0][0]) begin n_rls0++; rls_edge0 = ecount; end
        if (rpt[0][0]) begin
            n_rpt0++;
            last_rpt0 = ecount;
            if (first_rpt0 < 0) first_rpt0 = ecount;
        end
        if (lvl[0][1] | prs[0][1] | rls[0][1]) n_ev1++;
        if (prs[1] == 2'b11 && both_edge_b < 0) both_edge_b = ecount;
    endtask

    initial begin
        int         base;
        int         dur_a [2];
        int         dur_b [2];
        int         durs [7] = '{1, 2, 3, 5, 8, 20, 40};
        logic [1:0] ra, rb;
        logic       ren;

        clear_events();
        repeat (3) cycle(2'b00, 2'b11, 1'b1, 1'b1);
        repeat (4) cycle(2'b00, 2'b11, 1'b1, 1'b0);

        // Clean press held into auto-repeat.
        clear_events();
        base = ecount;
        repeat (30) cycle(2'b01, 2'b10, 1'b1, 1'b0);
        check_eq("clean_press_latency", prs_edge0 - base, 6);
        check_eq("clean_press_count", n_prs0, 1);
        check_eq("ch1_quiet", n_ev1, 0);
        check_eq("first_repeat_gap", first_rpt0 - prs_edge0, 10);
        check_eq("repeat_count", n_rpt0, 5);

        // Release stops repeats.
        clear_events();
        base = ecount;
        repeat (12) cycle(2'b00, 2'b11, 1'b1, 1'b0);
        check_eq("release_latency", rls_edge0 - base, 6);
        check_eq("release_count", n_rls0, 1);
        check_eq("no_repeat_after_release", 32'(last_rpt0 > rls_edge0), 0);

        // Bounce then settle high.
        clear_events();
        for (int j = 0; j < 12; j++) begin
            ra = ((j / 2) % 2 == 0) ? 2'b01 : 2'b00;
            cycle(ra, ~ra, 1'b1, 1'b0);
        end
        base = ecount;
        repeat (12) cycle(2'b01, 2'b10, 1'b1, 1'b0);
        check_eq("bounce_press_count", n_prs0, 1);
        check_eq("bounce_settle_latency", prs_edge0 - base, 6);
        repeat (12) cycle(2'b00, 2'b11, 1'b1, 1'b0);

        // Short glitch on channel 1.
        clear_events();
        repeat (3) cycle(2'b10, 2'b01, 1'b1, 1'b0);
        repeat (12) cycle(2'b00, 2'b11, 1'b1, 1'b0);
        check_eq("glitch_rejected", n_ev1, 0);

        // Hold with repeat disabled, then enable while held.
        clear_events();
        repeat (30) cycle(2'b01, 2'b10, 1'b0, 1'b0);
        check_eq("disabled_repeat_count", n_rpt0, 0);
        check_eq("disabled_press_count", n_prs0, 1);
        base = ecount;
        repeat (12) cycle(2'b01, 2'b10, 1'b1, 1'b0);
        check_eq("enable_hold_gap", first_rpt0 - base, 10);
        repeat (12) cycle(2'b00, 2'b11, 1'b1, 1'b0);

        // Reset while repeating with the input still held.
        clear_events();
        repeat (20) cycle(2'b01, 2'b10, 1'b1, 1'b0);
        cycle(2'b01, 2'b10, 1'b1, 1'b1);
        base = ecount;
        clear_events();
        repeat (12) cycle(2'b01, 2'b10, 1'b1, 1'b0);
        check_eq("reset_refire_latency", prs_edge0 - base, 6);
        check_eq("reset_no_release", n_rls0, 0);
        repeat (12) cycle(2'b00, 2'b11, 1'b1, 1'b0);

        // Both active-low channels pressed together.
        clear_events();
        base = ecount;
        repeat (10) cycle(2'b11, 2'b00, 1'b1, 1'b0);
        check_eq("both_press_same_edge", both_edge_b - base, 6);
        repeat (12) cycle(2'b00, 2'b11, 1'b1, 1'b0);

        // Random phase: bursty inputs, occasional enable toggles and resets.
        ra = 2'b00; rb = 2'b11; ren = 1'b1;
        dur_a = '{0, 0};
        dur_b = '{0, 0};
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (dur_a[c] == 0) begin
                    ra[c] = 1'($urandom_range(0, 1));
                    dur_a[c] = durs[$urandom_range(0, 6)];
                end
                if (dur_b[c] == 0) begin
                    rb[c] = 1'($urandom_range(0, 1));
                    dur_b[c] = durs[$urandom_range(0, 6)];
                end
                dur_a[c]--;
                dur_b[c]--;
            end
            if ($urandom_range(0, 199) == 0) ren = ~ren;
            cycle(ra, rb, ren, ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
